// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Moore control sequencer for the multicycle CPU datapath. One state per
// cycle; every control strobe and mux select is decoded from the current
// state, so nothing can glitch high while reset holds the machine in INIT.
// The opcode is captured in DECODE so later states never see a changed
// instruction register value.

module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  // State encodings are visible on the debug port, so they are fixed values.
  localparam logic [3:0] ST_INIT     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_EXEC_R   = 4'd3;
  localparam logic [3:0] ST_EXEC_I   = 4'd4;
  localparam logic [3:0] ST_ALUWB    = 4'd5;
  localparam logic [3:0] ST_MEMADDR  = 4'd6;
  localparam logic [3:0] ST_MEMREAD  = 4'd7;
  localparam logic [3:0] ST_MEMWB    = 4'd8;
  localparam logic [3:0] ST_MEMWRITE = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;
  localparam logic [3:0] ST_HALT     = 4'd12;

  // Opcode map of the supported instruction set.
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_SLT  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000111;

  // ALU function codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Mux select codes.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;

  logic [3:0]  r_state;
  logic [3:0]  w_nextState;
  logic [5:0]  r_op;
  logic [31:0] r_instrCount;
  logic        w_retire;

  // State register; reset drops straight back to INIT from anywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the opcode while in DECODE so execute states use a stable copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= '0;
    end else if (r_state == ST_DECODE) begin
      r_op <= Opcode;
    end
  end

  // Next-state logic; only DECODE looks at the live opcode.
  always_comb begin
    w_nextState = ST_INIT;
    case (r_state)
      ST_INIT:   w_nextState = ST_FETCH;
      ST_FETCH:  w_nextState = ST_DECODE;
      ST_DECODE: begin
        case (Opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: w_nextState = ST_EXEC_R;
          OP_ADDI:                               w_nextState = ST_EXEC_I;
          OP_LW, OP_SW:                          w_nextState = ST_MEMADDR;
          OP_BNE:                                w_nextState = ST_BRANCH;
          OP_J:                                  w_nextState = ST_JUMP;
          default:                               w_nextState = ST_HALT;
        endcase
      end
      ST_EXEC_R:   w_nextState = ST_ALUWB;
      ST_EXEC_I:   w_nextState = ST_ALUWB;
      ST_ALUWB:    w_nextState = ST_FETCH;
      ST_MEMADDR:  w_nextState = (r_op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  w_nextState = ST_MEMWB;
      ST_MEMWB:    w_nextState = ST_FETCH;
      ST_MEMWRITE: w_nextState = ST_FETCH;
      ST_BRANCH:   w_nextState = ST_FETCH;
      ST_JUMP:     w_nextState = ST_FETCH;
      ST_HALT:     w_nextState = ST_HALT;
      default:     w_nextState = ST_INIT;
    endcase
  end

  // An instruction retires on the edge leaving its final state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_ALUWB, ST_MEMWB, ST_MEMWRITE, ST_BRANCH, ST_JUMP: w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, free-running wrap at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instrCount <= '0;
    end else if (w_retire) begin
      r_instrCount <= r_instrCount + 32'd1;
    end
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALU_ADD;
    PCSource    = PCSRC_ALU;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_ONE;
        PCWrite = 1'b1;
      end
      ST_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = r_op[2:0];
      end
      ST_EXEC_I, ST_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      ST_ALUWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b0;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      ST_MEMWRITE: begin
        MemWrite = 1'b1;
        ALUSrcB  = SRCB_REG;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_BR;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JMP;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_instrCount;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Directed plus randomized instruction stream for mc_control_fsm. The
// reference model describes each instruction as the list of states it walks
// through and the strobes each state must show.

module tb_mc_control_fsm;

  typedef int stateQ_t[$];

  logic        clk;
  logic        reset;
  logic [5:0]  Opcode;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IRWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemToReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSource;
  logic [3:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  logic [14:0] obsCtl;
  int          checks;
  int          errors;
  logic [31:0] modelCount;

  mc_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .MemToReg    (MemToReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  assign obsCtl = {PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, MemToReg,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // States visited from FETCH until the instruction hands back to FETCH.
  function automatic stateQ_t pathFor(input logic [5:0] op);
    stateQ_t p;
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100: p = '{1, 2, 3, 5};
      6'b001000: p = '{1, 2, 4, 5};
      6'b100011: p = '{1, 2, 6, 7, 8};
      6'b101011: p = '{1, 2, 6, 9};
      6'b000101: p = '{1, 2, 10};
      6'b000111: p = '{1, 2, 11};
      default:   p = '{1, 2, 12};
    endcase
    return p;
  endfunction

  // Control word each state must present, in the same packing as obsCtl.
  function automatic logic [14:0] expCtl(input int st, input logic [2:0] aluOp);
    logic       pw, pwc, ir, mw, rw, m2r, asa, h;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    pw = 0; pwc = 0; ir = 0; mw = 0; rw = 0; m2r = 0; asa = 0; h = 0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    case (st)
      1:  begin ir = 1; pw = 1; asb = 2'b01; end
      3:  begin asa = 1; aop = aluOp; end
      4:  begin asa = 1; asb = 2'b10; end
      5:  begin rw = 1; end
      6:  begin asa = 1; asb = 2'b10; end
      8:  begin rw = 1; m2r = 1; end
      9:  begin mw = 1; end
      10: begin asa = 1; aop = 3'b001; pwc = 1; psrc = 2'b01; end
      11: begin pw = 1; psrc = 2'b10; end
      12: begin h = 1; end
      default: h = 0;
    endcase
    return {pw, pwc, ir, mw, rw, m2r, asa, asb, aop, psrc, h};
  endfunction

  // One comparison: counts it, and on disagreement counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare state, control word and counter against the model in one go.
  task automatic checkAll(input string tag, input int st, input logic [2:0] aluOp);
    checkOutput({tag, " state"}, {28'd0, state}, st);
    checkOutput({tag, " ctl"}, {17'd0, obsCtl}, {17'd0, expCtl(st, aluOp)});
    checkOutput({tag, " count"}, instr_count, modelCount);
  endtask

  // Run one instruction from FETCH; alt is shown on Opcode outside DECODE.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] alt);
    stateQ_t p;
    p = pathFor(op);
    foreach (p[i]) begin
      checkAll($sformatf("op%06b step%0d", op, i), p[i], op[2:0]);
      Opcode = (p[i] == 2) ? op : alt;
      @(posedge clk);
      @(negedge clk);
    end
    modelCount = modelCount + 32'd1;
  endtask

  // Asynchronous reset a little after a falling edge, then restart to FETCH.
  task automatic doReset(input string tag);
    #2 reset = 1'b1;
    #1;
    modelCount = 32'd0;
    checkAll({tag, " async"}, 0, 3'b000);
    @(negedge clk);
    checkAll({tag, " held"}, 0, 3'b000);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] legal [10];
  int unsigned pick;

  initial begin
    legal = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
              6'b001000, 6'b100011, 6'b101011, 6'b000101, 6'b000111};
    checks     = 0;
    errors     = 0;
    modelCount = 32'd0;
    reset      = 1'b1;
    Opcode     = 6'd0;

    // Power-up reset, then mid-cycle reset pulse and an ADD.
    @(negedge clk);
    checkAll("powerup", 0, 3'b000);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    doReset("reset1");
    applyStimulus(6'b000000, 6'($urandom));
    checkOutput("add count", instr_count, 32'd1);

    // Memory, branch and jump sequences.
    applyStimulus(6'b100011, 6'($urandom));
    applyStimulus(6'b101011, 6'($urandom));
    applyStimulus(6'b000101, 6'($urandom));
    applyStimulus(6'b000111, 6'($urandom));

    // SUB with Opcode switched to OR after DECODE must keep ALUOp 001.
    applyStimulus(6'b000001, 6'b000011);

    // Random legal instruction stream with random Opcode noise elsewhere.
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(9, 0);
      applyStimulus(legal[pick], 6'($urandom));
    end

    // Reset in the middle of an LW: abandoned, nothing counted.
    checkAll("lw partial fetch", 1, 3'b000);
    Opcode = 6'b100011;
    @(posedge clk);
    @(negedge clk);
    checkAll("lw partial decode", 2, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checkAll("lw partial memaddr", 6, 3'b000);
    doReset("reset2");
    applyStimulus(6'b001000, 6'($urandom));

    // Illegal opcode parks in HALT with strobes low and the counter frozen.
    checkAll("illegal fetch", 1, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checkAll("illegal decode", 2, 3'b000);
    Opcode = 6'b111111;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      checkAll($sformatf("halt cyc%0d", c), 12, 3'b000);
      Opcode = 6'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    doReset("reset3");

    // Counter wrap: preload all ones, one ADDI brings it to zero.
    force dut.r_instrCount = 32'hFFFF_FFFF;
    #1 release dut.r_instrCount;
    modelCount = 32'hFFFF_FFFF;
    applyStimulus(6'b001000, 6'($urandom));
    checkAll("after wrap", 1, 3'b000);
    checkOutput("wrap value", instr_count, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Moore-style control state machine that sequences the multicycle CPU datapath. It takes the 6-bit opcode latched in the instruction register and drives every datapath control strobe and mux select, one state per cycle. It also exposes the current state, a halted flag and a retired-instruction counter for the top-level testbench.

## Interface

Parameters: none.

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces state INIT and clears counter
- Opcode  input  6  opcode from instruction register; sampled in DECODE only
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by datapath branch flag
- IRWrite  output  1  instruction register load
- MemWrite  output  1  data memory write strobe
- RegWrite  output  1  register file write strobe
- MemToReg  output  1  write-back select: 1 = memory data reg, 0 = ALUOut reg
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A reg
- ALUSrcB  output  2  ALU B select: 00 = B reg, 01 = constant 1, 10 = sign-extended immediate
- ALUOp  output  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 slt
- PCSource  output  2  PC input: 00 = live ALU result, 01 = branch target, 10 = jump target
- state  output  4  current state encoding (debug)
- halted  output  1  high while in HALT
- instr_count  output  32  retired-instruction counter

## Operation

Opcode map (anything else is illegal):
- 000000 ADD, 000001 SUB, 000010 AND, 000011 OR, 000100 SLT (register ALU ops; ALUOp = opcode[2:0])
- 001000 ADDI, 100011 LW, 101011 SW, 000101 BNE, 000111 J

States and encodings. Outputs not listed are 0.
- INIT (0): all outputs 0. Next state is FETCH.
- FETCH (1): IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00, PCWrite=1. Next state is DECODE.
- DECODE (2): no strobes. Next state by opcode: register ALU op → EXEC_R; ADDI → EXEC_I; LW/SW → MEMADDR; BNE → BRANCH; J → JUMP; illegal → HALT.
- EXEC_R (3): ALUSrcA=1, ALUSrcB=00, ALUOp=latched op. Next state is ALUWB.
- EXEC_I (4): ALUSrcA=1, ALUSrcB=10, ALUOp=add. Next state is ALUWB.
- ALUWB (5): RegWrite=1, MemToReg=0. Next state is FETCH.
- MEMADDR (6): ALUSrcA=1, ALUSrcB=10, ALUOp=add. Next state is MEMREAD for LW, MEMWRITE for SW.
- MEMREAD (7): no strobes; memory data register captures. Next state is MEMWB.
- MEMWB (8): RegWrite=1, MemToReg=1. Next state is FETCH.
- MEMWRITE (9): MemWrite=1, ALUSrcB=00, because memory write data is the ALU B input. Next state is FETCH.
- BRANCH (10): ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01. Next state is FETCH.
- JUMP (11): PCWrite=1, PCSource=10. Next state is FETCH.
- HALT (12): all strobes 0, halted=1. Stays in HALT until reset.

Latched operation:
- In DECODE the block copies Opcode into an internal op register.
- EXEC_R and MEMADDR use that copy, never the live Opcode.

Retired-instruction counter:
- instr_count increments by 1 on the clock edge leaving ALUWB, MEMWB, MEMWRITE, BRANCH or JUMP.
- It is 32 bits and wraps from 0xFFFFFFFF to 0.
- An illegal opcode does not count.

Unused encodings:
- State encodings 13–15 go to INIT on the next edge, with all outputs 0.

## Timing

- Reset: asynchronous assert. While reset is high: state=INIT, all control outputs 0, halted=0, instr_count=0.
- Reset deassert: FETCH is entered on the first rising edge after deassertion.
- Reset mid-instruction: the instruction is abandoned immediately and no strobe glitches high. A partially executed instruction is not counted.
- Outputs are purely a function of state (Moore). Strobes are valid for the whole cycle and are sampled by the datapath on the closing edge.
- Cycles per instruction, counted from FETCH entry:
  - register ALU ops and ADDI: 4
  - LW: 5
  - SW: 4
  - BNE: 3
  - J: 3
- Opcode is sampled on the DECODE → next-state edge. The instruction register is loaded at the end of FETCH, so Opcode is stable throughout DECODE.
- BNE taken or not-taken takes identical cycles. Whether the PC updates is decided in the datapath by PCWriteCond AND branch.

## Test plan

- Reset and ADD sequence: assert reset mid-cycle, then Opcode=000000. Required response:
  - outputs go 0 asynchronously and state=0
  - after deassert the state sequence is 1, 2, 3, 5, 1
  - RegWrite=1 only in state 5
  - instr_count=1 after the sequence
- LW then SW:
  - LW: state sequence 1, 2, 6, 7, 8, 1; MemToReg=1 with RegWrite=1 in state 8
  - SW: state sequence 1, 2, 6, 9, 1; MemWrite=1 with ALUSrcB=00 in state 9
  - instr_count=2
- BNE and J:
  - BNE: state 10 drives ALUOp=001, PCWriteCond=1, PCSource=01, PCWrite=0
  - J: state 11 drives PCWrite=1, PCSource=10
  - each takes 3 cycles
- Opcode change after DECODE: present SUB (000001) in DECODE, then change Opcode to 000011 during EXEC_R → ALUOp stays 001.
- Illegal opcode 111111: the block reaches HALT (12) with halted=1 and all strobes 0 for 20 cycles. instr_count is unchanged. Reset returns it to INIT.
- Counter wrap: with instr_count at 0xFFFFFFFF, after one ADDI it reads 0x00000000.
